// File: rtl/if_fetch_stage.sv
// ============================================================================
// if_fetch_stage
//
// Instruction-fetch stage of the 5-stage pipeline. It owns the PC and issues
// fetches to instruction memory over a valid/ready handshake, with at most
// one request outstanding. It also drives the load enable, PC and instruction
// of the IF/ID pipeline register.
//
// The stage inserts NOP bubbles while memory is slow. It buffers an accepted
// instruction while the pipeline is stalled. On a redirect it drains or drops
// wrong-path fetches.
//
// Optional feature (macro IF_PERF_CNT_EN):
//   When defined, two 32-bit counters are added:
//     perf_fetch  - cycles where IF/ID loads a real instruction
//     perf_bubble - cycles where IF/ID loads an inserted NOP
//   When undefined, neither the ports nor the counters exist.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   stall        in   hazard unit: hold IF/ID and PC
//   redirect     in   taken branch/jump: flush and refetch
//   redirect_pc  in   redirect target (bits [1:0] forced to 0)
//   imem_req     out  fetch request valid
//   imem_addr    out  fetch byte address
//   imem_ready   in   memory accepts and returns data this cycle
//   imem_rdata   in   instruction returned with imem_ready
//   ifid_en      out  IF/ID load enable
//   PC_IF        out  PC for IF/ID
//   inst_IF      out  instruction for IF/ID
//   perf_fetch   out  (IF_PERF_CNT_EN) real-instruction load count
//   perf_bubble  out  (IF_PERF_CNT_EN) NOP-bubble load count
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        ifid_en,
    output logic [31:0] PC_IF,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] inst_IF,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_bubble
`else
    output logic [31:0] inst_IF
`endif
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,   // request at pc outstanding
        ST_HOLD  = 2'd1,   // accepted instruction parked while stalled
        ST_DRAIN = 2'd2    // wrong-path request still pending, must complete
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] hold_buf_reg, hold_buf_next;
    logic [31:0] drain_addr_reg, drain_addr_next;

    // Set when IF/ID loads a genuine fetched instruction, not an inserted NOP.
    logic        real_inst;

    // Masking rather than slicing keeps the target word-aligned.
    logic [31:0] redirect_target;
    assign redirect_target = redirect_pc & ~32'h0000_0003;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_REQ;
            pc_reg         <= RESET_PC;
            hold_buf_reg   <= NOP_INST;
            drain_addr_reg <= 32'h0000_0000;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            hold_buf_reg   <= hold_buf_next;
            drain_addr_reg <= drain_addr_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        hold_buf_next   = hold_buf_reg;
        drain_addr_next = drain_addr_reg;

        if (redirect) begin
            pc_next = redirect_target;
            unique case (state_reg)
                ST_REQ: begin
                    // An unanswered request cannot be withdrawn, so it is
                    // drained at its original address before refetching.
                    if (!imem_ready) begin
                        drain_addr_next = pc_reg;
                        state_next      = ST_DRAIN;
                    end else begin
                        state_next = ST_REQ;
                    end
                end
                ST_HOLD: state_next = ST_REQ;
                ST_DRAIN: state_next = imem_ready ? ST_REQ : ST_DRAIN;
                default: state_next = ST_REQ;
            endcase
        end else begin
            unique case (state_reg)
                ST_REQ: begin
                    if (imem_ready) begin
                        if (stall) begin
                            hold_buf_next = imem_rdata;
                            state_next    = ST_HOLD;
                        end else begin
                            pc_next = pc_reg + 32'd4;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        pc_next    = pc_reg + 32'd4;
                        state_next = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ready) state_next = ST_REQ;
                end
                default: state_next = ST_REQ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_reg;
        ifid_en   = 1'b0;
        PC_IF     = pc_reg;
        inst_IF   = NOP_INST;
        real_inst = 1'b0;

        // The request side must stay stable until it is accepted, so it
        // depends only on state, even during a redirect.
        unique case (state_reg)
            ST_REQ: begin
                imem_req  = 1'b1;
                imem_addr = pc_reg;
                ifid_en   = !stall;
                if (imem_ready) begin
                    inst_IF   = imem_rdata;
                    real_inst = !stall;
                end
            end
            ST_HOLD: begin
                imem_req  = 1'b0;
                inst_IF   = hold_buf_reg;
                ifid_en   = !stall;
                real_inst = !stall;
            end
            ST_DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr_reg;
                ifid_en   = !stall;
            end
            default: ;
        endcase

        // A redirect flushes IF/ID with a bubble even while stalled.
        if (redirect) begin
            ifid_en   = 1'b1;
            inst_IF   = NOP_INST;
            real_inst = 1'b0;
        end
    end

`ifdef IF_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters (wrap naturally at 2^32)
    // ------------------------------------------------------------------
    logic [31:0] perf_fetch_reg, perf_bubble_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_reg  <= 32'h0;
            perf_bubble_reg <= 32'h0;
        end else if (ifid_en) begin
            if (real_inst) perf_fetch_reg  <= perf_fetch_reg + 32'd1;
            else           perf_bubble_reg <= perf_bubble_reg + 32'd1;
        end
    end

    assign perf_fetch  = perf_fetch_reg;
    assign perf_bubble = perf_bubble_reg;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// tb_if_fetch_stage
//
// Bench for if_fetch_stage. Memory returns addr ^ 32'hA5A5_0000.
//
// Each step drives the inputs on the falling edge and samples the outputs
// 1 ns later. The outputs are compared against a behavioural model. The model
// tracks the PC, an optional parked instruction and an optional drain address.
// It is advanced after the rising edge.
//
// The bench runs the directed scenarios first and then a randomized phase.
// ============================================================================
`timescale 1ns/1ps
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] MEM_KEY  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic        ifid_en;
    logic [31:0] PC_IF;
    logic [31:0] inst_IF;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_bubble;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Observed values from the most recent step.
    logic        obs_req, obs_en;
    logic [31:0] obs_addr, obs_inst, obs_pc;

    // Reference model
    logic [31:0] m_pc;
    logic        m_holding;
    logic [31:0] m_buf;
    logic        m_draining;
    logic [31:0] m_daddr;
    logic [31:0] m_fetch, m_bubble;

    always #5 clk = ~clk;

    // The memory answers whatever address is presented.
    assign imem_rdata = imem_addr ^ MEM_KEY;

    if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .ifid_en(ifid_en),
        .PC_IF(PC_IF),
`ifdef IF_PERF_CNT_EN
        .inst_IF(inst_IF),
        .perf_fetch(perf_fetch),
        .perf_bubble(perf_bubble)
`else
        .inst_IF(inst_IF)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc       = RESET_PC;
        m_holding  = 1'b0;
        m_buf      = NOP_INST;
        m_draining = 1'b0;
        m_daddr    = 32'h0;
        m_fetch    = 32'h0;
        m_bubble   = 32'h0;
    endtask

    // One clock cycle: drive, check combinational outputs, clock, advance model.
    task automatic step(input logic s_rst, input logic s_stall, input logic s_redir,
                        input logic [31:0] s_rpc, input logic s_ready);
        logic        e_req, e_en, fetching, real_load;
        logic [31:0] e_addr, e_inst;
        @(negedge clk);
        rst         = s_rst;
        stall       = s_stall;
        redirect    = s_redir;
        redirect_pc = s_rpc;
        imem_ready  = s_ready;
        #1;
        obs_req  = imem_req;
        obs_addr = imem_addr;
        obs_en   = ifid_en;
        obs_inst = inst_IF;
        obs_pc   = PC_IF;

        fetching  = !m_holding && !m_draining;
        e_req     = !m_holding;
        e_addr    = m_draining ? m_daddr : m_pc;
        // IF/ID loads whenever the pipeline moves or a flush is forced.
        e_en      = s_redir || !s_stall;
        real_load = e_en && !s_redir && (m_holding || (fetching && s_ready));
        if (s_redir)        e_inst = NOP_INST;
        else if (m_holding) e_inst = m_buf;
        else if (fetching && s_ready) e_inst = m_pc ^ MEM_KEY;
        else                e_inst = NOP_INST;

        if (!s_rst) begin
            check("imem_req", {31'b0, obs_req}, {31'b0, e_req});
            if (e_req) check("imem_addr", obs_addr, e_addr);
            check("ifid_en", {31'b0, obs_en}, {31'b0, e_en});
            if (e_en) begin
                check("PC_IF", obs_pc, m_pc);
                check("inst_IF", obs_inst, e_inst);
            end
        end
`ifdef IF_PERF_CNT_EN
        check("perf_fetch", perf_fetch, m_fetch);
        check("perf_bubble", perf_bubble, m_bubble);
`endif
        $display("[TB] t=%0t rst=%0b stall=%0b redir=%0b ready=%0b req=%0b addr=%h en=%0b pc_if=%h inst=%h",
                 $time, s_rst, s_stall, s_redir, s_ready, obs_req, obs_addr, obs_en, obs_pc, obs_inst);

        @(posedge clk);
        if (s_rst) begin
            model_reset();
        end else begin
            if (e_en) begin
                if (real_load) m_fetch  = m_fetch + 32'd1;
                else           m_bubble = m_bubble + 32'd1;
            end
            if (s_redir) begin
                if (fetching && !s_ready) begin
                    m_draining = 1'b1;
                    m_daddr    = m_pc;
                end else if (m_draining && s_ready) begin
                    m_draining = 1'b0;
                end
                m_holding = 1'b0;
                m_pc      = {s_rpc[31:2], 2'b00};
            end else if (m_holding) begin
                if (!s_stall) begin
                    m_holding = 1'b0;
                    m_pc      = m_pc + 32'd4;
                end
            end else if (m_draining) begin
                if (s_ready) m_draining = 1'b0;
            end else if (s_ready) begin
                if (s_stall) begin
                    m_holding = 1'b1;
                    m_buf     = m_pc ^ MEM_KEY;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    initial begin
        model_reset();

        // Reset, then check the reset state.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("reset_req", {31'b0, obs_req}, 32'd1);
        check("reset_addr", obs_addr, RESET_PC);

        // Zero-wait streaming: 0,4,8,C.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            check("stream_addr", obs_addr, 32'(i * 4));
        end

        // Slow memory at 0x10: two bubbles, then the real instruction.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, (i == 2));
            check("slow_pc", obs_pc, 32'h10);
        end
        check("slow_inst", obs_inst, 32'h10 ^ MEM_KEY);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Stall while ready at 0x20.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("stall_en", {31'b0, obs_en}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("hold_req", {31'b0, obs_req}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("hold_pc", obs_pc, 32'h20);
        check("hold_inst", obs_inst, 32'h20 ^ MEM_KEY);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("after_hold_addr", obs_addr, 32'h24);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect to 0x103 while the request at 0x40 is pending.
        step(1'b0, 1'b0, 1'b1, 32'h103, 1'b0);
        check("redir_inst", obs_inst, NOP_INST);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("drain_addr", obs_addr, 32'h40);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("drain_inst", obs_inst, NOP_INST);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("target_addr", obs_addr, 32'h100);

        // Redirect and stall in the same cycle.
        step(1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
        check("rs_en", {31'b0, obs_en}, 32'd1);
        check("rs_inst", obs_inst, NOP_INST);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("rs_addr", obs_addr, 32'h200);

        // Reset during DRAIN.
        step(1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("rst_drain_addr", obs_addr, RESET_PC);
        check("rst_drain_req", {31'b0, obs_req}, 32'd1);
`ifdef IF_PERF_CNT_EN
        check("rst_perf_fetch", perf_fetch, 32'h0);
        check("rst_perf_bubble", perf_bubble, 32'h0);
`endif

        // PC wrap at the top of the address space.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("wrap_top", obs_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("wrap_zero", obs_addr, 32'h0);

        // Randomized phase.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(99) < 1),
                 ($urandom_range(99) < 25),
                 ($urandom_range(99) < 10),
                 $urandom,
                 ($urandom_range(99) < 60));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
